// File: rtl/bake_square_pkg.sv
// rtl/bake_square_pkg.sv - shared constants and FSM state type for the tile baker
package bake_square_pkg;
  localparam int         TILE_PX             = 20;
  localparam int         SCREEN_W            = 160;
  localparam int         GRID_W              = 8;
  localparam int         GRID_H              = 6;
  localparam logic [8:0] TRANSPARENT_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/bake_square_tile_address_gen.sv
// rtl/bake_square_tile_address_gen.sv - tile pixel counters, ROM-latency delayed copies and background address
module tile_address_gen
  import bake_square_pkg::*;
#(
  parameter int TILE_W = TILE_PX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  gx,
  input  logic [2:0]  gy,
  output logic [8:0]  sprite_address,
  output logic [14:0] bg_address,
  output logic        last
);

  logic [4:0]  px, py, px_d, py_d;
  logic [14:0] row, col;

  always_ff @(posedge clk) begin
    if (reset) begin
      px   <= '0;
      py   <= '0;
      px_d <= '0;
      py_d <= '0;
    end else if (en) begin
      // delayed pair tracks the pixel whose ROM data arrives this cycle
      px_d <= px;
      py_d <= py;
      if (px == 5'(TILE_W - 1)) begin
        px <= '0;
        py <= (py == 5'(TILE_W - 1)) ? 5'd0 : py + 5'd1;
      end else begin
        px <= px + 5'd1;
      end
    end
  end

  assign sprite_address = {4'b0, py} * 9'(TILE_W) + {4'b0, px};

  assign row        = {12'b0, gy} * 15'(TILE_W) + {10'b0, py_d};
  assign col        = {12'b0, gx} * 15'(TILE_W) + {10'b0, px_d};
  assign bg_address = row * 15'(SCREEN_W) + col;

  assign last = (px_d == 5'(TILE_W - 1)) && (py_d == 5'(TILE_W - 1));

endmodule

// File: rtl/bake_square.sv
// rtl/bake_square.sv - copies one sprite tile from ROM into the background RAM, skipping transparent pixels
module bake_square
  import bake_square_pkg::*;
#(
  parameter logic [8:0] TRANSPARENT = TRANSPARENT_DEFAULT,
  parameter int         TILE        = TILE_PX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  grid_x,
  input  logic [3:0]  grid_y,
  output logic [8:0]  sprite_address,
  input  logic [8:0]  sprite_q,
  output logic [14:0] bg_address,
  output logic [8:0]  bg_data,
  output logic        bg_wren,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t      state;
  logic [2:0]  gx, gy;
  logic        last;
  logic        cnt_en;
  logic [14:0] pix_address;

  // counters step once in PRIME and on every WRITE cycle but the last, so they end wrapped at 0
  assign cnt_en = (state == S_PRIME) || ((state == S_WRITE) && !last);

  tile_address_gen #(
    .TILE_W (TILE)
  ) u_addr (
    .clk            (clk),
    .reset          (reset),
    .en             (cnt_en),
    .gx             (gx),
    .gy             (gy),
    .sprite_address (sprite_address),
    .bg_address     (pix_address),
    .last           (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      gx         <= '0;
      gy         <= '0;
      bg_address <= '0;
      bg_data    <= '0;
      bg_wren    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      bg_wren <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if ((grid_x > 4'(GRID_W - 1)) || (grid_y > 4'(GRID_H - 1))) begin
              error <= 1'b1;
            end else begin
              gx    <= grid_x[2:0];
              gy    <= grid_y[2:0];
              busy  <= 1'b1;
              state <= S_PRIME;
            end
          end
        end
        S_PRIME: state <= S_WRITE;
        S_WRITE: begin
          bg_wren    <= (sprite_q != TRANSPARENT);
          bg_data    <= sprite_q;
          bg_address <= pix_address;
          if (last) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bake_square.sv
// tb/tb_bake_square.sv - scoreboard bench for bake_square with directed tile bakes
module tb_bake_square;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  grid_x = '0;
  logic [3:0]  grid_y = '0;
  logic [8:0]  sprite_address;
  logic [8:0]  sprite_q = '0;
  logic [14:0] bg_address;
  logic [8:0]  bg_data;
  logic        bg_wren;
  logic        busy;
  logic        done;
  logic        error;

  bake_square dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .grid_x         (grid_x),
    .grid_y         (grid_y),
    .sprite_address (sprite_address),
    .sprite_q       (sprite_q),
    .bg_address     (bg_address),
    .bg_data        (bg_data),
    .bg_wren        (bg_wren),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  int exp_addr[$];
  int exp_data[$];
  int writes, done_cnt, err_cnt, busy_cycles;
  int first_addr, last_addr, max_addr, first_cyc, done_cyc, t0;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: mode 0 opaque (q = addr), mode 1 even pixels transparent
  always @(posedge clk) begin
    if (mode == 1 && sprite_address[0] == 1'b0) sprite_q <= 9'h1FF;
    else sprite_q <= sprite_address;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bg_wren) begin
      writes++;
      if (writes == 1) begin
        first_addr = bg_address;
        first_cyc  = cyc;
      end
      last_addr = bg_address;
      if (bg_address > max_addr) max_addr = bg_address;
      if (exp_addr.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("bg_address", bg_address, exp_addr.pop_front());
        chk("bg_data", bg_data, exp_data.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", busy, 0);
    end
    if (error) err_cnt++;
    if (busy) busy_cycles++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    writes = 0; done_cnt = 0; err_cnt = 0; busy_cycles = 0;
    first_addr = -1; last_addr = -1; max_addr = 0; first_cyc = -1; done_cyc = -1;
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic push_expected(input int gx, input int gy, input int m);
    for (int k = 0; k < 400; k++) begin
      int px, py, d;
      px = k % 20;
      py = k / 20;
      d  = (m == 1 && (k % 2) == 0) ? 511 : k;
      if (d != 511) begin
        exp_addr.push_back((gy * 20 + py) * 160 + gx * 20 + px);
        exp_data.push_back(d);
      end
    end
  endtask

  task automatic do_start(input int gx, input int gy);
    tick();
    start  = 1'b1;
    grid_x = 4'(gx);
    grid_y = 4'(gy);
    tick();
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      tick();
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic bake(input string tag, input int gx, input int gy, input int m,
                      input int e_writes, input int e_first, input int e_last, input int e_lat,
                      input int restart_at);
    clear_stats();
    mode = m;
    push_expected(gx, gy, m);
    do_start(gx, gy);
    if (restart_at > 0) begin
      repeat (restart_at - 2) tick();
      start  = 1'b1;
      grid_x = 4'd2;
      grid_y = 4'd2;
      tick();
      start = 1'b0;
    end
    wait_done();
    chk({tag, "_writes"}, writes, e_writes);
    chk({tag, "_first_addr"}, first_addr, e_first);
    chk({tag, "_last_addr"}, last_addr, e_last);
    chk({tag, "_first_latency"}, first_cyc - t0, e_lat);
    chk({tag, "_done_latency"}, done_cyc - t0, 402);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_queue_left"}, exp_addr.size(), 0);
    chk({tag, "_max_addr_ok"}, int'(max_addr <= 19199), 1);
  endtask

  initial begin
    clear_stats();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wren", bg_wren, 0);
    chk("rst_sprite_address", sprite_address, 0);
    reset = 1'b0;
    tick();

    bake("g00", 0, 0, 0, 400, 0, 3059, 2, 0);
    bake("g75", 7, 5, 0, 400, 16140, 19199, 2, 0);
    bake("g32_transp", 3, 2, 1, 200, 6461, 9519, 3, 0);
    bake("restart", 0, 0, 0, 400, 0, 3059, 2, 100);

    clear_stats();
    mode = 0;
    do_start(8, 0);
    repeat (2) tick();
    chk("err_x_count", err_cnt, 1);
    do_start(0, 6);
    repeat (2) tick();
    chk("err_y_count", err_cnt, 2);
    repeat (5) tick();
    chk("err_writes", writes, 0);
    chk("err_busy_cycles", busy_cycles, 0);

    clear_stats();
    push_expected(1, 1, 0);
    do_start(1, 1);
    begin
      int n;
      n = 0;
      while (writes < 150 && n < 400) begin
        tick();
        n++;
      end
    end
    chk("abort_reached_150", writes, 150);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_wren_off", bg_wren, 0);
    chk("abort_busy_off", busy, 0);
    exp_addr.delete();
    exp_data.delete();
    repeat (450) tick();
    chk("abort_writes", writes, 150);
    chk("abort_no_done", done_cnt, 0);

    bake("after_abort", 0, 0, 0, 400, 0, 3059, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bake_square.md
BAKE_SQUARE -- requirements
Module: bake_square

Interface
REQ-001 Parameter TRANSPARENT, default 9'h1FF: sprite colour that is never written to the background.
REQ-002 Parameter TILE, default 20: tile edge in pixels.
REQ-003 Ports, in order:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to bake one tile.
- grid_x  in  4  tile column, valid 0..7.
- grid_y  in  4  tile row, valid 0..5.
- sprite_address  out  9  tile ROM read address, 0..399.
- sprite_q  in  9  tile ROM data; registered, valid one cycle after the address.
- bg_address  out  15  address into the 160x120 background RAM.
- bg_data  out  9  pixel written to the background RAM.
- bg_wren  out  1  background RAM write enable.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when a bake finishes.
- error  out  1  one-cycle pulse when start is rejected.

Function
REQ-004 start is sampled only in IDLE; grid_x and grid_y are latched on the accepting edge.
REQ-005 start is ignored while busy; in-flight operation unaffected.
REQ-006 grid_x>7 or grid_y>5 at start: error pulses next cycle; no writes; stays IDLE; busy stays 0.
REQ-007 FSM states: IDLE -> PRIME (1 cycle, first ROM address presented) -> WRITE (400 cycles) -> DONE (1 cycle) -> IDLE.
REQ-008 Pixel counters: px 0..19 inner, py 0..19 outer; sprite_address = py*20+px; row-major order.
REQ-009 ROM latency compensation: px/py delayed one stage; bg_address uses the delayed pair, so pixel k is written one cycle after address k is issued.
REQ-010 bg_address = (grid_y*20+py_d)*160 + (grid_x*20+px_d), computed at 15 bits, no truncation; maximum 19199.
REQ-011 bg_data = sprite_q; bg_wren = 1 in WRITE only when sprite_q != TRANSPARENT.
REQ-012 The write for (19,19) occurs in the last WRITE cycle; done pulses in the following cycle (DONE); busy falls with done.
REQ-013 Latency: start accepted at edge 0 -> first write at edge 2 -> done high after edge 402.
REQ-014 Counters wrap to 0 at the end; a new start is accepted in the first cycle back in IDLE.
REQ-015 bg_wren is 0 outside WRITE; bg_address/bg_data are don't-care when bg_wren=0.
REQ-016 Total background writes per bake = 400 minus the count of transparent sprite pixels.

Reset
REQ-017 reset forces IDLE, px=py=0, bg_wren=0, busy=0, done=0, error=0, and sprite_address=0 on the next edge.
REQ-018 reset has priority over start in the same cycle.
REQ-019 reset mid-bake aborts with no further writes; done never pulses for the aborted bake.

Structure
REQ-020 The shared package holds TILE, the screen width of 160, the grid limits 8x6, the TRANSPARENT default, and the FSM state enum.
REQ-021 A single sub-module, tile_address_gen, contains the px/py counters, their delayed copies, and the bg_address arithmetic; the FSM stays in bake_square.

Verification
REQ-022 Fully opaque sprite (q=addr%512), grid (0,0) -> 400 writes; first bg_address=0, last=3059; done pulse 1 cycle after the last write.
REQ-023 Grid (7,5), opaque sprite -> first bg_address=16140 (100*160+140), last=19199; no address exceeds 19199.
REQ-024 Sprite with every even pixel = 9'h1FF, grid (3,2) -> exactly 200 writes, only at odd pixel indices; done timing unchanged (cycle 402).
REQ-025 start with grid_x=8, then start with grid_y=6 -> error pulses once each; bg_wren never asserted; busy stays 0.
REQ-026 Second start at cycle 100 of a bake -> ignored; exactly one done; write count 400.
REQ-027 reset asserted at write 150 -> bg_wren=0 from the next cycle; no done pulse; a fresh start afterwards completes normally from pixel (0,0).
